// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-side register block: register map,
// access-FSM encoding and small datapath helpers.
package ppu_pkg;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  localparam logic [13:0] VRAM_STEP_ROW = 14'd32;
  localparam logic [13:0] VRAM_STEP_COL = 14'd1;

  typedef enum logic [0:0] {
    ACC_IDLE = 1'b0,
    ACC_HOLD = 1'b1
  } acc_state_t;

  // PPUCTRL bit 2 selects a row (32) or column (1) step through the nametable
  function automatic logic [13:0] vram_next(input logic [13:0] addr, input logic inc32);
    if (inc32) begin
      vram_next = addr + VRAM_STEP_ROW;
    end else begin
      vram_next = addr + VRAM_STEP_COL;
    end
  endfunction

  function automatic logic [7:0] status_byte(input logic vb, input logic s0, input logic ovf);
    status_byte = {vb, s0, ovf, 5'b00000};
  endfunction

endpackage

// File: rtl/ppu_reg_responder_chk.sv
// Protocol checks for the register responder's access sequencing.
module ppu_reg_responder_chk (
  input logic clk,
  input logic reset,
  input logic fill_pend,
  input logic stb7,
  input logic busy,
  input logic any_stb
);

  a_no_fill_collision: assert property (@(posedge clk) disable iff (reset) !(fill_pend && stb7));
  a_no_stb_in_hold:    assert property (@(posedge clk) disable iff (reset) !(busy && any_stb));

endmodule

// File: rtl/reg_access_detect.sv
// Turns the CPU select/write levels into single-cycle read/write strobes,
// one per held access, using an IDLE/HOLD FSM.
module reg_access_detect
  import ppu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic we,
  output logic wr_stb,
  output logic rd_stb,
  output logic busy
);

  acc_state_t state_r;
  acc_state_t state_s;
  logic       prev_sel_r;
  logic       prev_we_r;
  logic       we_chg_r;
  logic       we_chg_s;
  logic       stb_s;

  // State register plus previous-cycle samples of sel and WE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ACC_IDLE;
      prev_sel_r <= 1'b1;  // a select held across reset must not look like a new access
      prev_we_r  <= 1'b0;
      we_chg_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      prev_sel_r <= sel;
      prev_we_r  <= we;
      we_chg_r   <= we_chg_s;
    end
  end

  // Next state and strobe generation
  always_comb begin
    state_s  = state_r;
    stb_s    = 1'b0;
    we_chg_s = 1'b0;
    case (state_r)
      ACC_IDLE: begin
        if (sel && (!prev_sel_r || we_chg_r)) begin
          stb_s   = 1'b1;
          state_s = ACC_HOLD;
        end else begin
          state_s = ACC_IDLE;
        end
      end
      ACC_HOLD: begin
        if (!sel) begin
          state_s = ACC_IDLE;
        end else if (we != prev_we_r) begin
          // direction flip under a held select: re-arm through IDLE
          state_s  = ACC_IDLE;
          we_chg_s = 1'b1;
        end else begin
          state_s = ACC_HOLD;
        end
      end
      default: begin
        state_s = ACC_IDLE;
      end
    endcase
  end

  assign wr_stb = stb_s & we;
  assign rd_stb = stb_s & ~we;
  assign busy   = (state_r == ACC_HOLD);

endmodule

// File: rtl/ppu_reg_responder.sv
// CPU-facing PPU register block ($2000-$2007): register state, status flags,
// open-bus read latch and OAM/VRAM access strobes.
module ppu_reg_responder
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ppu_reg_cs,
  input  logic [2:0]  ppu_reg_addr,
  input  logic        WE,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        sprite0_hit,
  input  logic        sprite_ovf,
  output logic [7:0]  ppuctrl,
  output logic [7:0]  ppumask,
  output logic        nmi,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  input  logic [7:0]  oam_rdata,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y
);

  logic        sel_s;
  logic        wr_stb_s;
  logic        rd_stb_s;
  logic        busy_s;
  logic        rd2_s;
  logic        stb7_s;
  logic [7:0]  rd_val_s;
  logic [7:0]  data_out_s;

  logic [7:0]  ppuctrl_r;
  logic [7:0]  ppumask_r;
  logic [7:0]  oam_addr_r;
  logic [7:0]  scroll_x_r;
  logic [7:0]  scroll_y_r;
  logic [7:0]  read_buf_r;
  logic [7:0]  rd_latch_r;
  logic [13:0] addr_t_r;
  logic [13:0] vram_addr_r;
  logic        toggle_r;
  logic        vblank_r;
  logic        sprite0_r;
  logic        ovf_r;
  logic        copy_pend_r;
  logic        fill_pend_r;

  assign sel_s = ~ppu_reg_cs;

  reg_access_detect u_detect (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel_s),
    .we     (WE),
    .wr_stb (wr_stb_s),
    .rd_stb (rd_stb_s),
    .busy   (busy_s)
  );

  assign rd2_s  = rd_stb_s & (ppu_reg_addr == PPUSTATUS);
  assign stb7_s = (wr_stb_s | rd_stb_s) & (ppu_reg_addr == PPUDATA);

  // Register file, address/scroll latches and deferred VRAM address updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ppuctrl_r   <= 8'h00;
      ppumask_r   <= 8'h00;
      oam_addr_r  <= 8'h00;
      scroll_x_r  <= 8'h00;
      scroll_y_r  <= 8'h00;
      read_buf_r  <= 8'h00;
      addr_t_r    <= 14'h0000;
      vram_addr_r <= 14'h0000;
      toggle_r    <= 1'b0;
      copy_pend_r <= 1'b0;
      fill_pend_r <= 1'b0;
    end else begin
      copy_pend_r <= 1'b0;
      fill_pend_r <= 1'b0;
      if (copy_pend_r) begin
        vram_addr_r <= addr_t_r;
      end
      if (fill_pend_r) begin
        read_buf_r  <= vram_rdata;
        vram_addr_r <= vram_next(vram_addr_r, ppuctrl_r[2]);
      end
      if (wr_stb_s) begin
        case (ppu_reg_addr)
          PPUCTRL: ppuctrl_r <= data_in;
          PPUMASK: ppumask_r <= data_in;
          OAMADDR: oam_addr_r <= data_in;
          OAMDATA: oam_addr_r <= oam_addr_r + 8'd1;
          PPUSCROLL: begin
            if (toggle_r) begin
              scroll_y_r <= data_in;
            end else begin
              scroll_x_r <= data_in;
            end
            toggle_r <= ~toggle_r;
          end
          PPUADDR: begin
            if (toggle_r) begin
              addr_t_r[7:0] <= data_in;
              copy_pend_r   <= 1'b1;
            end else begin
              addr_t_r[13:8] <= data_in[5:0];
            end
            toggle_r <= ~toggle_r;
          end
          PPUDATA: vram_addr_r <= vram_next(vram_addr_r, ppuctrl_r[2]);
          default: ;
        endcase
      end else if (rd_stb_s) begin
        case (ppu_reg_addr)
          PPUSTATUS: toggle_r <= 1'b0;
          PPUDATA:   fill_pend_r <= 1'b1;  // vram_rdata lands next cycle
          default:   ;
        endcase
      end
    end
  end

  // Status flags: vblank_clr beats vblank_set, which beats a status-read clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_r  <= 1'b0;
      sprite0_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      if (vblank_clr) begin
        vblank_r  <= 1'b0;
        sprite0_r <= 1'b0;
        ovf_r     <= 1'b0;
      end else begin
        if (vblank_set) begin
          vblank_r <= 1'b1;
        end else if (rd2_s) begin
          vblank_r <= 1'b0;
        end
        if (sprite0_hit) begin
          sprite0_r <= 1'b1;
        end
        if (sprite_ovf) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  // Read latch: holds the strobe-cycle value for HOLD and open-bus reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_latch_r <= 8'h00;
    end else if (rd_stb_s) begin
      rd_latch_r <= rd_val_s;
    end
  end

  // Pre-side-effect read value and read data mux
  always_comb begin
    rd_val_s   = rd_latch_r;
    data_out_s = rd_latch_r;
    case (ppu_reg_addr)
      PPUSTATUS: rd_val_s = status_byte(vblank_r, sprite0_r, ovf_r);
      OAMDATA:   rd_val_s = oam_rdata;
      PPUDATA:   rd_val_s = read_buf_r;
      default:   rd_val_s = rd_latch_r;
    endcase
    if (rd_stb_s) begin
      data_out_s = rd_val_s;
    end else begin
      data_out_s = rd_latch_r;
    end
  end

  assign data_out   = data_out_s;
  assign ppuctrl    = ppuctrl_r;
  assign ppumask    = ppumask_r;
  assign nmi        = vblank_r & ppuctrl_r[7];
  assign oam_addr   = oam_addr_r;
  assign oam_wdata  = data_in;
  assign oam_we     = wr_stb_s & (ppu_reg_addr == OAMDATA);
  assign vram_addr  = vram_addr_r;
  assign vram_wdata = data_in;
  assign vram_we    = wr_stb_s & (ppu_reg_addr == PPUDATA);
  assign vram_re    = rd_stb_s & (ppu_reg_addr == PPUDATA);
  assign scroll_x   = scroll_x_r;
  assign scroll_y   = scroll_y_r;

  ppu_reg_responder_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .fill_pend (fill_pend_r),
    .stb7      (stb7_s),
    .busy      (busy_s),
    .any_stb   (wr_stb_s | rd_stb_s)
  );

endmodule
